// File: rtl/fifo_pkg.sv
// Shared constants and sizing helpers for the parametrised synchronous FIFO.
package fifo_pkg;

  // Read-mode selector values for the FWFT parameter.
  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Pointer width: enough bits to address DEPTH entries.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Count width: one extra bit so that a completely full FIFO (count == DEPTH)
  // can be represented.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when v is a non-zero power of two.
  function automatic bit fifo_is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage array: synchronous write, asynchronous read.
// Contents are deliberately not reset; the control logic never presents an
// entry that has not been written since the last reset or flush.
module fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Store the write word on the rising edge when the write is accepted.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO: configurable width/depth, almost-full and
// almost-empty thresholds, standard or first-word-fall-through read, a
// synchronous flush and one-cycle overflow/underflow error pulses.
//
// Handshake: a write is accepted on a rising edge when wr_en is high and the
// registered full flag is low; a read is accepted when rd_en is high and the
// registered empty flag is low. Requests made against full/empty are dropped
// and reported by a one-cycle overflow/underflow pulse. flush overrides both
// requests for that cycle. All flags are decoded from the registered count,
// so there is no combinational path from wr_en/rd_en to any flag.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = FIFO_MODE_STD
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

  // Reject illegal configurations at elaboration.
  if (!fifo_is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must lie in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must lie in 0..DEPTH-1");
  end
  if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
    $error("sync_fifo_param: FWFT must be 0 or 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_WIDTH must be at least 1");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Flags come straight from the registered occupancy.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // In FWFT mode the head word is shown directly while the FIFO holds data;
  // when empty, the last presented word is held.
  assign data_out = (FWFT == FIFO_MODE_FWFT && !empty) ? ram_rdata : dout_q;

  // Accept decisions use only registered flags; flush blocks both sides.
  always_comb begin
    wr_acc = wr_en && !full  && !flush;
    rd_acc = rd_en && !empty && !flush;
  end

  // Next-state for pointers, occupancy, output register and error pulses.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    dout_d      = dout_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
      overflow_d  = wr_en && full;
      underflow_d = rd_en && empty;
      if (FWFT == FIFO_MODE_FWFT) begin
        // Track the presented word so it can be held once the FIFO drains.
        if (!empty) begin
          dout_d = ram_rdata;
        end
      end else if (rd_acc) begin
        dout_d = ram_rdata;
      end
    end
  end

  // Control state registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one standard-mode and one FWFT instance
// (DATA_WIDTH=8, DEPTH=16, AF_THRESH=14, AE_THRESH=2).
module tb_sync_fifo_param;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- standard-mode instance ----------------
  logic       s_flush, s_wr, s_rd;
  logic [7:0] s_din, s_dout;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [4:0] s_cnt;

  sync_fifo_param #(
    .DATA_WIDTH (8), .DEPTH (16), .AF_THRESH (14), .AE_THRESH (2), .FWFT (0)
  ) dut_std (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (s_flush),
    .wr_en        (s_wr),
    .data_in      (s_din),
    .rd_en        (s_rd),
    .data_out     (s_dout),
    .full         (s_full),
    .empty        (s_empty),
    .almost_full  (s_af),
    .almost_empty (s_ae),
    .count        (s_cnt),
    .overflow     (s_ovf),
    .underflow    (s_udf)
  );

  // ---------------- FWFT instance ----------------
  logic       f_flush, f_wr, f_rd;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_cnt;

  sync_fifo_param #(
    .DATA_WIDTH (8), .DEPTH (16), .AF_THRESH (14), .AE_THRESH (2), .FWFT (1)
  ) dut_fwft (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (f_flush),
    .wr_en        (f_wr),
    .data_in      (f_din),
    .rd_en        (f_rd),
    .data_out     (f_dout),
    .full         (f_full),
    .empty        (f_empty),
    .almost_full  (f_af),
    .almost_empty (f_ae),
    .count        (f_cnt),
    .overflow     (f_ovf),
    .underflow    (f_udf)
  );

  // ---------------- scoreboard ----------------
  int         vectors;
  int         miscompares;
  logic [7:0] exp_q[$];
  logic [7:0] exp_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Apply one cycle of requests to the standard instance, then check #1 after the edge.
  task automatic s_cycle(input logic wr, input logic [7:0] din, input logic rd, input logic fl);
    s_wr = wr; s_din = din; s_rd = rd; s_flush = fl;
    @(posedge clk);
    #1;
    s_wr = 1'b0; s_rd = 1'b0; s_flush = 1'b0;
  endtask

  task automatic f_cycle(input logic wr, input logic [7:0] din, input logic rd);
    f_wr = wr; f_din = din; f_rd = rd; f_flush = 1'b0;
    @(posedge clk);
    #1;
    f_wr = 1'b0; f_rd = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    s_flush = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_din = 8'h00;
    f_flush = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_din = 8'h00;

    // Reset values
    #8;
    chk("rst count",     s_cnt,   0);
    chk("rst empty",     s_empty, 1);
    chk("rst ae",        s_ae,    1);
    chk("rst full",      s_full,  0);
    chk("rst af",        s_af,    0);
    chk("rst ovf",       s_ovf,   0);
    chk("rst udf",       s_udf,   0);
    chk("rst dout",      s_dout,  0);
    chk("rst f empty",   f_empty, 1);
    chk("rst f dout",    f_dout,  0);
    #4 rst_n = 1'b1;                 // release at t=12, away from edges
    @(posedge clk); #1;

    // FWFT: word appears with no rd_en, pop empties
    f_cycle(1'b1, 8'hFF, 1'b0);
    chk("fwft wr empty", f_empty, 0);
    chk("fwft wr dout",  f_dout,  8'hFF);
    chk("fwft wr count", f_cnt,   1);
    f_cycle(1'b0, 8'h00, 1'b0);
    chk("fwft idle dout", f_dout, 8'hFF);
    f_cycle(1'b0, 8'h00, 1'b1);
    chk("fwft pop empty", f_empty, 1);
    chk("fwft pop count", f_cnt,   0);
    chk("fwft pop hold",  f_dout,  8'hFF);
    f_cycle(1'b1, 8'h11, 1'b0);
    chk("fwft w11 dout", f_dout, 8'h11);
    f_cycle(1'b1, 8'h22, 1'b0);
    chk("fwft w22 dout", f_dout, 8'h11);
    f_cycle(1'b0, 8'h00, 1'b1);
    chk("fwft pop11 dout", f_dout, 8'h22);
    f_cycle(1'b1, 8'h33, 1'b1);
    chk("fwft rw dout",  f_dout, 8'h33);
    chk("fwft rw count", f_cnt,  1);

    // Standard: fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      s_cycle(1'b1, 8'(i), 1'b0, 1'b0);
      chk($sformatf("fill%0d count", i), s_cnt,  i);
      chk($sformatf("fill%0d af", i),    s_af,   (i >= 14) ? 1 : 0);
      chk($sformatf("fill%0d full", i),  s_full, (i == 16) ? 1 : 0);
    end
    s_cycle(1'b1, 8'h77, 1'b0, 1'b0);
    chk("ovf pulse", s_ovf, 1);
    chk("ovf count", s_cnt, 16);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf clear", s_ovf, 0);

    // Standard: drain in order
    for (int i = 1; i <= 16; i++) begin
      s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk($sformatf("rd%0d dout", i),  s_dout,  i);
      chk($sformatf("rd%0d count", i), s_cnt,   16 - i);
      chk($sformatf("rd%0d empty", i), s_empty, (i == 16) ? 1 : 0);
      chk($sformatf("rd%0d ae", i),    s_ae,    (16 - i <= 2) ? 1 : 0);
    end
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("udf pulse", s_udf,  1);
    chk("udf hold",  s_dout, 8'h10);
    s_cycle(1'b0, 8'h00, 1'b0, 1'b0);
    chk("udf clear", s_udf, 0);

    // Sustained read+write at count 8 across pointer wrap
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      s_cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    end
    chk("pre rw count", s_cnt, 8);
    for (int k = 0; k < 20; k++) begin
      exp_q.push_back(8'h28 + 8'(k));
      s_cycle(1'b1, 8'h28 + 8'(k), 1'b1, 1'b0);
      exp_w = exp_q.pop_front();
      chk($sformatf("rw%0d dout", k),  s_dout, exp_w);
      chk($sformatf("rw%0d count", k), s_cnt,  8);
    end
    for (int i = 0; i < 3; i++) begin
      s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
      exp_w = exp_q.pop_front();
      chk($sformatf("tail%0d dout", i), s_dout, exp_w);
    end
    chk("pre flush count", s_cnt, 5);

    // Flush with a concurrent write
    s_cycle(1'b1, 8'hEE, 1'b0, 1'b1);
    exp_q.delete();
    chk("flush count", s_cnt,   0);
    chk("flush empty", s_empty, 1);
    chk("flush ovf",   s_ovf,   0);
    chk("flush udf",   s_udf,   0);
    chk("flush dout",  s_dout,  0);
    s_cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("post flush dout", s_dout, 8'h5A);

    // Empty: write accepted, read rejected
    s_cycle(1'b1, 8'h66, 1'b1, 1'b0);
    chk("empty rw udf",   s_udf,  1);
    chk("empty rw count", s_cnt,  1);
    chk("empty rw dout",  s_dout, 8'h5A);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("empty rw read", s_dout, 8'h66);

    // Full: read accepted, write rejected
    for (int i = 0; i < 16; i++) s_cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0);
    chk("refill full", s_full, 1);
    s_cycle(1'b1, 8'h99, 1'b1, 1'b0);
    chk("full rw ovf",   s_ovf,  1);
    chk("full rw count", s_cnt,  15);
    chk("full rw dout",  s_dout, 8'h40);

    // Asynchronous reset mid-burst at count 9
    s_cycle(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) s_cycle(1'b1, 8'h50 + 8'(i), 1'b0, 1'b0);
    chk("pre arst count", s_cnt, 9);
    s_wr = 1'b1; s_din = 8'h59;
    #3 rst_n = 1'b0;
    #1;
    chk("arst count", s_cnt,   0);
    chk("arst empty", s_empty, 1);
    chk("arst ae",    s_ae,    1);
    chk("arst af",    s_af,    0);
    chk("arst dout",  s_dout,  0);
    s_wr = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel ovf",   s_ovf, 0);
    chk("rel udf",   s_udf, 0);
    chk("rel count", s_cnt, 0);
    s_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("rel wr count", s_cnt, 1);
    s_cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("rel rd dout", s_dout, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
